// File: rtl/idfi_log_fetch.sv
`default_nettype none
// ============================================================================
// Module      : idfi_log_fetch
// Description : Upstream feeder of the iDFI checker. On an access request it
//               reads one 3-word log entry (id, addr, data) from the shared log
//               table over an AXI4-Lite-style read channel. It keeps a single
//               read outstanding at a time and assembles the words into a
//               96-bit record. Completion is signalled with a done pulse and
//               failure with an error pulse.
// Ports       : clk, rst                 clock / async active-high reset
//               i_rqAccess, i_logAddr    request and entry base address
//               o_logData, o_logDone     assembled record and done pulse
//               o_fetchErr, o_busy       error pulse, busy status
//               o_araddr/o_arvalid/i_arready            read address channel
//               i_rdata/i_rresp/i_rvalid/o_rready       read data channel
// Revision    : 1.0 - initial release
// ============================================================================
module idfi_log_fetch #(
    parameter int                      N_ADDR_WIDTH      = 32,
    parameter int                      N_DATA_WIDTH      = 32,
    parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = 32'h1FEFF800,
    parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDREND  = 32'h1FEFFBF0,
    parameter int                      TIMEOUT_CYCLES    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_rqAccess,
    input  logic [N_ADDR_WIDTH-1:0]   i_logAddr,
    output logic [3*N_DATA_WIDTH-1:0] o_logData,
    output logic                      o_logDone,
    output logic                      o_fetchErr,
    output logic                      o_busy,
    output logic [N_ADDR_WIDTH-1:0]   o_araddr,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [N_DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rvalid,
    output logic                      o_rready
);

    localparam int                c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [N_ADDR_WIDTH-1:0]     r_base;
    logic                        r_addr_ok;
    logic [1:0]                  r_beat;
    logic                        r_err;
    logic [c_tmo_w-1:0]          r_tmo_cnt;
    logic [2*N_DATA_WIDTH-1:0]   r_shadow;
    logic [3*N_DATA_WIDTH-1:0]   r_log_data;

    logic                        w_addr_legal;
    logic                        w_arvalid;
    logic                        w_rready;
    logic                        w_tmo_hit;
    logic                        w_rd_err;
    logic [N_ADDR_WIDTH-1:0]     w_beat_off;

    assign w_addr_legal = (i_logAddr[1:0] == 2'b00) &&
                          (i_logAddr >= LOGTABLE_ADDRINIT) &&
                          (i_logAddr <= LOGTABLE_ADDREND);
    assign w_tmo_hit    = (r_tmo_cnt == c_tmo_last);
    assign w_rd_err     = (i_rresp != 2'b00);
    assign w_beat_off   = {{(N_ADDR_WIDTH-4){1'b0}}, r_beat, 2'b00};

    // Address legality is captured with the request and acted on in the first
    // AR cycle: an illegal base leaves AR for ERR without ever raising arvalid,
    // which keeps the range comparators off the request-to-state path.
    always_comb begin
        w_next    = r_state;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_rqAccess) begin
                    w_next = S_AR;
                end
            end
            S_AR: begin
                if (!r_addr_ok) begin
                    w_next = S_ERR;
                end else begin
                    w_arvalid = 1'b1;
                    if (i_arready) begin
                        w_next = S_R;
                    end else if (w_tmo_hit) begin
                        w_next = S_ERR;
                    end
                end
            end
            S_R: begin
                w_rready = 1'b1;
                if (i_rvalid) begin
                    if (r_beat != 2'd2) begin
                        w_next = S_AR;
                    end else if (r_err || w_rd_err) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DONE;
                    end
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_addr_ok  <= 1'b0;
            r_beat     <= 2'd0;
            r_err      <= 1'b0;
            r_tmo_cnt  <= '0;
            r_shadow   <= '0;
            r_log_data <= '0;
        end else begin
            // Wait counter restarts on every state change so each AR and each
            // R handshake gets its own budget.
            if (w_next != r_state) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_AR || r_state == S_R) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_rqAccess) begin
                        r_base    <= i_logAddr;
                        r_addr_ok <= w_addr_legal;
                        r_beat    <= 2'd0;
                        r_err     <= 1'b0;
                    end
                end
                S_R: begin
                    if (i_rvalid) begin
                        if (w_rd_err) begin
                            r_err <= 1'b1;
                        end
                        // First two words wait in the shadow; the visible
                        // record only changes once the last word arrives clean.
                        case (r_beat)
                            2'd0:    r_shadow[2*N_DATA_WIDTH-1:N_DATA_WIDTH] <= i_rdata;
                            2'd1:    r_shadow[N_DATA_WIDTH-1:0]              <= i_rdata;
                            default: begin
                                if (!(r_err || w_rd_err)) begin
                                    r_log_data <= {r_shadow, i_rdata};
                                end
                            end
                        endcase
                        if (r_beat != 2'd2) begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_logData  = r_log_data;
    assign o_logDone  = (r_state == S_DONE);
    assign o_fetchErr = (r_state == S_ERR);
    assign o_busy     = (r_state != S_IDLE);
    assign o_arvalid  = w_arvalid;
    assign o_rready   = w_rready;
    assign o_araddr   = w_arvalid ? (r_base + w_beat_off) : '0;

endmodule
`default_nettype wire

// File: tb/tb_idfi_log_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_idfi_log_fetch
// Description : Self-checking bench for idfi_log_fetch. A behavioural memory
//               slave with per-beat handshake delays serves reads; a
//               transaction-level model predicts completion cycle, outcome,
//               record value and accepted addresses for each fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idfi_log_fetch;

    localparam int          TMO   = 8;
    localparam logic [31:0] AINIT = 32'h1FEFF800;
    localparam logic [31:0] AEND  = 32'h1FEFFBF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rq_access = 1'b0;
    logic [31:0] log_addr = '0;
    logic [95:0] log_data;
    logic        log_done, fetch_err, busy;
    logic [31:0] araddr;
    logic        arvalid, rready;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;

    idfi_log_fetch #(
        .N_ADDR_WIDTH(32), .N_DATA_WIDTH(32),
        .LOGTABLE_ADDRINIT(AINIT), .LOGTABLE_ADDREND(AEND),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_rqAccess(rq_access), .i_logAddr(log_addr),
        .o_logData(log_data), .o_logDone(log_done), .o_fetchErr(fetch_err),
        .o_busy(busy), .o_araddr(araddr), .o_arvalid(arvalid),
        .i_arready(arready), .i_rdata(rdata), .i_rresp(rresp),
        .i_rvalid(rvalid), .o_rready(rready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // memory and slave configuration
    logic [31:0] mem [logic [31:0]];
    int          ar_dly [3];
    int          r_dly  [3];
    int          bad_beat = -1;

    // slave bookkeeping
    logic [31:0] acc_addr [$];
    int          arv_cycles = 0;
    bit          pending = 0;
    logic [31:0] pend_addr = '0;
    int          pend_beat = 0;
    int          arw = 0;
    int          rw = 0;

    // model / compare state
    bit          active = 0;
    int          cyc = 0;
    int          exp_end = 0;
    bit          exp_err = 0;
    int          exp_arv = 0;
    logic [95:0] model_data = '0;
    logic [95:0] exp_new = '0;
    logic [31:0] exp_addrs [$];
    int          seen_done = -1;
    int          seen_err = -1;

    function automatic void chk(string name, logic [95:0] got, logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A0000;
    endfunction

    // Transaction-level prediction: legality, per-beat cost in cycles
    // (delay + 1 for each handshake), timeout budget, sticky error.
    function automatic void plan(input logic [31:0] a);
        logic [31:0] w [3];
        int t;
        bit err;
        bit tmo;
        exp_addrs.delete();
        exp_arv = 0;
        if (a[1:0] != 2'b00 || a < AINIT || a > AEND) begin
            exp_end = 2;
            exp_err = 1'b1;
            exp_new = model_data;
            return;
        end
        t = 1; err = 1'b0; tmo = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (ar_dly[k] >= TMO) begin
                t += TMO; exp_arv += TMO; tmo = 1'b1; break;
            end
            t += ar_dly[k] + 1;
            exp_arv += ar_dly[k] + 1;
            exp_addrs.push_back(a + 32'(4 * k));
            if (r_dly[k] >= TMO) begin
                t += TMO; tmo = 1'b1; break;
            end
            t += r_dly[k] + 1;
            w[k] = mem_rd(a + 32'(4 * k));
            if (k == bad_beat) err = 1'b1;
        end
        exp_end = t;
        exp_err = err | tmo;
        exp_new = exp_err ? model_data : {w[0], w[1], w[2]};
    endfunction

    task automatic set_delays(input int a0, a1, a2, r0, r1, r2, bb);
        ar_dly[0] = a0; ar_dly[1] = a1; ar_dly[2] = a2;
        r_dly[0]  = r0; r_dly[1]  = r1; r_dly[2]  = r2;
        bad_beat  = bb;
    endtask

    task automatic clear_slave();
        acc_addr.delete();
        arv_cycles = 0;
        pending = 0;
        arw = 0;
        rw = 0;
    endtask

    // Memory slave: decides handshakes at the falling edge so they are taken
    // at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
                pending = 0; arw = 0; rw = 0;
            end else begin
                if (pending && rready) begin
                    if (rw >= r_dly[pend_beat]) begin
                        rvalid = 1'b1;
                        rdata  = mem_rd(pend_addr);
                        rresp  = (pend_beat == bad_beat) ? 2'b10 : 2'b00;
                        pending = 0;
                        rw = 0;
                    end else begin
                        rvalid = 1'b0;
                        rdata  = 32'hDEADBEEF;
                        rw++;
                    end
                end else begin
                    rvalid = 1'b0;
                    rresp  = 2'b00;
                end
                if (arvalid) begin
                    arv_cycles++;
                    if (acc_addr.size() < 3 && arw >= ar_dly[acc_addr.size()]) begin
                        arready   = 1'b1;
                        pend_beat = acc_addr.size();
                        pend_addr = araddr;
                        acc_addr.push_back(araddr);
                        pending   = 1;
                        arw       = 0;
                    end else begin
                        arready = 1'b0;
                        arw++;
                    end
                end else begin
                    arready = 1'b0;
                    arw = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model while a fetch is in flight.
    initial begin
        forever begin
            @(negedge clk);
            if (active) begin
                cyc++;
                if (log_done && seen_done < 0) seen_done = cyc;
                if (fetch_err && seen_err < 0) seen_err = cyc;
                chk("done_pulse", 96'(log_done), 96'(cyc == exp_end && !exp_err));
                chk("err_pulse",  96'(fetch_err), 96'(cyc == exp_end && exp_err));
                chk("busy",       96'(busy), 96'(cyc <= exp_end));
                chk("log_data",   log_data, (cyc >= exp_end) ? exp_new : model_data);
                chk("arvalid_and_rready", 96'(arvalid && rready), 96'd0);
                if (cyc > exp_end) active = 0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        plan(a);
        clear_slave();
        seen_done = -1;
        seen_err  = -1;
        @(negedge clk);
        rq_access = 1'b1;
        log_addr  = a;
        @(posedge clk);
        cyc = 0;
        active = 1;
        #1;
        rq_access = 1'b0;
        log_addr  = 32'hFFFF_FFFF;
        for (int i = 0; i < 400 && active; i++) @(posedge clk);
        if (active) begin
            tests++; fails++;
            $display("FAIL fetch_timeout: fetch at %h still running, expected end cycle %0d", a, exp_end);
            active = 0;
        end
        chk("arvalid_cycles", 96'(arv_cycles), 96'(exp_arv));
        chk("ar_count", 96'(acc_addr.size()), 96'(exp_addrs.size()));
        for (int k = 0; k < exp_addrs.size() && k < acc_addr.size(); k++)
            chk("ar_addr", 96'(acc_addr[k]), 96'(exp_addrs[k]));
        model_data = exp_new;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_log_data"}, log_data, 96'd0);
        chk({tag, "_ctrl"}, 96'({log_done, fetch_err, busy, arvalid, rready}), 96'd0);
        chk({tag, "_araddr"}, 96'(araddr), 96'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_delays(0, 0, 0, 0, 0, 0, -1);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // ready-tied bus
        mem[32'h1FEFF830] = 32'h00000002;
        mem[32'h1FEFF834] = 32'h00000014;
        mem[32'h1FEFF838] = 32'h00000020;
        fetch(32'h1FEFF830);
        chk("A_done_cycle", 96'(seen_done), 96'd7);
        chk("A_data", log_data, 96'h000000020000001400000020);
        chk("A_addr2", 96'(acc_addr.size() == 3 ? acc_addr[2] : 32'h0), 96'h1FEFF838);

        // delayed handshakes: 3-cycle arready stalls on beats 0/2, rvalid on beat 1
        mem[32'h1FEFF83C] = 32'h00000007;
        mem[32'h1FEFF840] = 32'h00000014;
        mem[32'h1FEFF844] = 32'h00000090;
        set_delays(3, 0, 3, 0, 3, 0, -1);
        fetch(32'h1FEFF83C);
        chk("B_done_cycle", 96'(seen_done), 96'd16);
        chk("B_data", log_data, 96'h000000070000001400000090);

        // illegal bases
        set_delays(0, 0, 0, 0, 0, 0, -1);
        fetch(32'h1FEFF832);
        chk("misaligned_err_cycle", 96'(seen_err), 96'd2);
        fetch(32'h1FEFF7FC);
        chk("below_err_cycle", 96'(seen_err), 96'd2);
        chk("below_no_ar", 96'(arv_cycles), 96'd0);
        fetch(32'h1FEFFBF4);
        chk("above_err_cycle", 96'(seen_err), 96'd2);
        chk("illegal_data_kept", log_data, 96'h000000070000001400000090);

        // error response on beat 1; beat 2 still read
        set_delays(0, 0, 0, 0, 0, 0, 1);
        fetch(32'h1FEFF900);
        chk("rresp_beats", 96'(acc_addr.size()), 96'd3);
        chk("rresp_err_cycle", 96'(seen_err), 96'd7);
        chk("rresp_no_done", 96'(seen_done), 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF);
        chk("rresp_data_kept", log_data, 96'h000000070000001400000090);

        // arready never comes
        set_delays(1000, 0, 0, 0, 0, 0, -1);
        fetch(32'h1FEFF910);
        chk("tmo_arvalid_cycles", 96'(arv_cycles), 96'd8);
        chk("tmo_err_cycle", 96'(seen_err), 96'd9);

        // reset in beat 1 with a request pulsed while busy
        set_delays(0, 0, 0, 0, 0, 0, -1);
        clear_slave();
        @(negedge clk);
        rq_access = 1'b1;
        log_addr  = 32'h1FEFF840;
        @(posedge clk); #1;
        rq_access = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rq_access = 1'b1;
        log_addr  = 32'h1FEFFA00;
        @(posedge clk); #1;
        rq_access = 1'b0;
        @(negedge clk);
        chk("busy_req_ignored_addr", 96'(araddr), 96'h1FEFF844);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_data = '0;
        fetch(32'h1FEFF83C);
        chk("post_rst_data", log_data, 96'h000000070000001400000090);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/idfi_log_fetch.md
Name: idfi_log_fetch

Overview:
- Upstream feeder of the iDFI checker: on the checker's access request it reads one 3-word log entry from the shared log table in memory over an AXI4-Lite-style read channel.
- It assembles the three words into the 96-bit log record and pulses done, or pulses error.
- Its outputs drive the checker's i_logData / i_logDone.
- Its inputs come from the checker's o_rqAccess / o_logAddr.

Parameters:
- N_ADDR_WIDTH, 32, address width on both sides.
- N_DATA_WIDTH, 32, memory word width; each log word is one beat.
- LOGTABLE_ADDRINIT, 32'h1FEFF800, lowest legal entry base address.
- LOGTABLE_ADDREND, 32'h1FEFFBF0, highest legal entry base address (the entry occupies base..base+8).
- TIMEOUT_CYCLES, 255, maximum wait cycles for any single AR or R handshake.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- i_rqAccess  in  1  fetch request; sampled only in IDLE.
- i_logAddr  in  N_ADDR_WIDTH  entry base address; captured with i_rqAccess.
- o_logData  out  3*N_DATA_WIDTH  assembled record {word@base, word@base+4, word@base+8}, i.e. {id, addr, data} MSB first.
- o_logDone  out  1  one-cycle pulse: o_logData is new and valid.
- o_fetchErr  out  1  one-cycle pulse: fetch failed.
- o_busy  out  1  high in every state except IDLE.
- o_araddr  out  N_ADDR_WIDTH  read address.
- o_arvalid  out  1  read address valid.
- i_arready  in  1  read address accepted.
- i_rdata  in  N_DATA_WIDTH  read data.
- i_rresp  in  2  read response; nonzero means error.
- i_rvalid  in  1  read data valid.
- o_rready  out  1  read data ready.

Behaviour:
- Reset values, applied immediately on rst:
  - all outputs 0, including o_logData = 0.
  - state IDLE; beat counter 0; timeout counter 0; error flag 0.
- States:
  - IDLE, AR, R, DONE, ERR.
- IDLE:
  - On a clk edge with i_rqAccess=1, latch i_logAddr.
  - If the address is aligned ([1:0]==0) and INIT <= addr <= END: beat=0, go to AR.
  - Otherwise go to ERR; no bus activity occurs.
- AR:
  - o_arvalid=1 and o_araddr = base + 4*beat.
  - Both are held stable until i_arready=1 is sampled, then go to R.
- R:
  - o_rready=1.
  - On i_rvalid=1, store i_rdata into slot beat: beat0 -> [95:64], beat1 -> [63:32], beat2 -> [31:0].
  - If i_rresp != 0, set the sticky error flag.
  - If beat<2: beat++, go to AR.
  - If beat==2: go to ERR when the flag is set, else go to DONE.
- Only one outstanding read at a time; o_arvalid and o_rready are never high together.
- DONE:
  - o_logDone=1 for exactly one cycle, then IDLE.
  - o_logData updates only on the DONE transition and holds until the next successful fetch.
  - Beats are collected in a shadow register, so partial data never appears on o_logData.
- ERR:
  - o_fetchErr=1 for one cycle, then IDLE.
  - o_logData keeps its previous value.
- Timeout:
  - The counter clears on each state entry and increments every cycle spent in AR or R.
  - When it reaches TIMEOUT_CYCLES, drop o_arvalid/o_rready and go to ERR.
- Latency with i_arready and i_rvalid tied high:
  - Request sampled at edge 0 -> o_arvalid at cycle 1.
  - Each beat takes 2 cycles.
  - o_logDone high in cycle 7.
- i_rqAccess while o_busy=1 is ignored (not queued).
- i_rqAccess held high through DONE is re-sampled in IDLE and starts a new fetch.
- i_rvalid while not in R is ignored.
- Reset mid-fetch: outputs clear asynchronously; any in-flight response is discarded by the interconnect (system rule).
- Address arithmetic: base + 4*beat is computed at N_ADDR_WIDTH and truncated. END guarantees no wrap for legal bases.

Test Plan:
- Ready-tied bus, i_logAddr=32'h1FEFF830, memory words 00000002/00000014/00000020:
  - o_araddr sequence is 1FEFF830, 1FEFF834, 1FEFF838.
  - o_logDone in cycle 7.
  - o_logData = 96'h000000020000001400000020.
- Second fetch at 32'h1FEFF83C with words 7/14/90 and 3-cycle i_arready and i_rvalid delays:
  - o_logData = 96'h000000070000001400000090.
  - o_logDone in cycle 16; the previous data holds until then.
- Illegal addresses 32'h1FEFF832 (misaligned), 32'h1FEFF7FC and 32'h1FEFFBF4:
  - o_fetchErr pulses in cycle 2.
  - o_arvalid never asserts; o_logData is unchanged.
- i_rresp=2'b10 on beat 1:
  - Beat 2 is still read.
  - o_fetchErr pulses and o_logDone does not.
  - o_logData is unchanged.
- i_arready held low with TIMEOUT_CYCLES=8:
  - o_arvalid is high for 8 cycles, then drops.
  - o_fetchErr pulses once; o_busy then falls.
- rst asserted mid-beat 1 with i_rqAccess pulsed while busy:
  - All outputs are 0 immediately.
  - The request during busy is ignored.
  - A fetch after rst releases completes normally.
